// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller.
// Register map: STATUS at offset 0, DATA at offset 4 (decoded on address bit 2 only).
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_t;

  localparam logic [31:0] UART_STATUS_OFF = 32'd0;
  localparam logic [31:0] UART_DATA_OFF   = 32'd4;

  localparam int ST_TX_READY = 0;
  localparam int ST_TX_IDLE  = 1;
  localparam int ST_OVERFLOW = 2;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/bus_if.sv
// Simple system-bus interface: independent write and read channels, registered read data.
interface bus_if;
  logic        wen;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        ren;
  logic [31:0] raddr;
  logic [31:0] rdata;

  modport slave  (input wen, waddr, wdata, ren, raddr, output rdata);
  modport master (output wen, waddr, wdata, ren, raddr, input rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit to separate full from empty.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped 8N1 UART transmitter: bus register decode, TX FIFO, baud counter and framing FSM.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic       TxD,
  bus_if.slave       bus,
  output logic [2:0] o_dbg_state
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  tx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_baud_cnt, w_baud_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_txd, w_txd_nxt;
  logic             r_parity, w_parity_nxt;
  logic             r_overflow;
  logic [31:0]      r_rdata;

  logic             w_bit_end;
  logic             w_pop;
  logic             w_full, w_empty;
  logic [7:0]       w_fifo_dout;
  logic             w_wr_data, w_push, w_drop, w_rd_status;
  logic [31:0]      w_status;
  logic             w_unused_bus;

  // Only address bit 2 is decoded: set selects DATA, clear selects STATUS.
  assign w_wr_data   = bus.wen && bus.waddr[2];
  assign w_push      = w_wr_data && !w_full;
  assign w_drop      = w_wr_data && w_full;
  assign w_rd_status = bus.ren && !bus.raddr[2];

  always_comb begin
    w_status              = '0;
    w_status[ST_TX_READY] = !w_full;
    w_status[ST_TX_IDLE]  = w_empty && (r_state == S_IDLE);
    w_status[ST_OVERFLOW] = r_overflow;
  end

  assign w_unused_bus = ^{bus.waddr[31:3], bus.waddr[1:0], bus.wdata[31:8],
                          bus.raddr[31:3], bus.raddr[1:0]};

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (bus.wdata[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_bit_end = (r_baud_cnt == CNT_W'(DIV - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = w_bit_end ? '0 : r_baud_cnt + 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_nxt  = w_fifo_dout;
          w_parity_nxt = ^w_fifo_dout;
          w_state_nxt  = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        // A waiting byte starts its frame straight out of STOP so frames stay contiguous.
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shift_nxt  = w_fifo_dout;
            w_parity_nxt = ^w_fifo_dout;
            w_state_nxt  = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
      end
    endcase
  end

  // TxD is registered from the next state so the line level lines up with the state it shows.
  always_comb begin
    w_txd_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_shift_nxt[0];
      S_PARITY: w_txd_nxt = w_parity_nxt;
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_parity   <= w_parity_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  // A dropped write outranks a same-cycle clearing STATUS read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (w_drop)           r_overflow <= 1'b1;
      else if (w_rd_status) r_overflow <= 1'b0;
      if (bus.ren)          r_rdata    <= bus.raddr[2] ? 32'd0 : w_status;
    end
  end

  assign TxD         = r_txd;
  assign bus.rdata   = r_rdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: table of single-byte frames, directed corner sequences,
// and randomized bursts checked against a frame-timing reference model.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DEPTH  = 4;
  localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * DIV;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txd;
  logic [2:0] dbg_state;
  bus_if      bus_i ();

  uart_tx_ctrl #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .TxD         (txd),
    .bus         (bus_i),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", 0, 1);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         checks   = 0;
  int         failures = 0;
  logic       hist[$];          // TxD value per cycle, index = cycle number
  logic [7:0] exp_q[$];         // bytes expected on the line
  int         exp_t[$];         // start-bit cycle of each expected frame
  int         last_end = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    hist.push_back(txd);
  endtask

  function automatic int cur();
    return hist.size() - 1;
  endfunction

  task automatic run_to(input int c);
    while (cur() < c) tick();
  endtask

  task automatic bus_op(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                        input logic re, input logic [31:0] ra, output logic [31:0] rd);
    bus_i.wen   = we;
    bus_i.waddr = wa;
    bus_i.wdata = wd;
    bus_i.ren   = re;
    bus_i.raddr = ra;
    tick();
    bus_i.wen = 1'b0;
    bus_i.ren = 1'b0;
    rd = bus_i.rdata;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    bus_op(1'b1, a, d, 1'b0, 32'd0, unused_rd);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_op(1'b0, 32'd0, 32'd0, 1'b1, a, d);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] st;
    int budget;
    budget = (DEPTH + 2) * FRAME + 50;
    st = 32'd0;
    while (budget > 0) begin
      rd(UART_STATUS_OFF, st);
      if (st[ST_TX_IDLE]) break;
      budget--;
    end
    check({"idle_", name}, {31'd0, st[ST_TX_IDLE]}, 32'd1);
  endtask

  // ---------------- reference model ----------------
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ($countones(b) % 2) == 1;
`endif
    return 1'b1;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    exp_t.delete();
    last_end = 0;
  endtask

  // A byte written at cycle w starts at w+2, or right after the previous frame if later.
  task automatic model_add(input logic [7:0] b, input int w);
    int s;
    s = (w + 2 > last_end) ? w + 2 : last_end;
    exp_q.push_back(b);
    exp_t.push_back(s);
    last_end = s + FRAME;
  endtask

  task automatic check_wave(input string name, input int from, input int to);
    int   mism;
    int   first;
    logic e;
    mism  = 0;
    first = -1;
    for (int c = from; c <= to; c++) begin
      e = 1'b1;
      for (int k = 0; k < exp_q.size(); k++)
        if (c >= exp_t[k] && c < exp_t[k] + FRAME)
          e = frame_bit(exp_q[k], (c - exp_t[k]) / DIV);
      if (hist[c] !== e) begin
        if (first < 0) first = c - from;
        mism++;
      end
    end
    checks++;
    if (mism != 0) begin
      failures++;
      $display("FAIL wave_%s: wrong_cycles=%0d required=0 (first at relative cycle %0d)",
               name, mism, first);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] d;
    int          t0;
    int          mism;
    logic        e;
    logic [10:0] fr;
    logic [31:0] a;
    logic [7:0]  b;

    bus_i.wen = 1'b0; bus_i.waddr = '0; bus_i.wdata = '0;
    bus_i.ren = 1'b0; bus_i.raddr = '0;

    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'hA5, 1'b0};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h07, 1'b1};
    vecs[5] = '{8'h80, 1'b1};

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_rdata", bus_i.rdata, 32'd0);
    rst = 1'b0;
    tick();
    rd(UART_STATUS_OFF, d);
    check("rst_status", d, 32'h3);

    // single-byte frames from the table
    foreach (vecs[i]) begin
`ifdef UART_TX_PARITY_EN
      fr = {1'b1, vecs[i].par, vecs[i].data, 1'b0};
`else
      fr = {2'b11, vecs[i].data, 1'b0};
`endif
      t0 = cur();
      wr(UART_DATA_OFF, {24'd0, vecs[i].data});
      run_to(t0 + 2);
      rd(UART_STATUS_OFF, d);
      check($sformatf("busy_status_%0d", i), d, 32'h1);
      run_to(t0 + 2 + FRAME);
      rd(UART_STATUS_OFF, d);
      check($sformatf("done_status_%0d", i), d, 32'h3);
      mism = 0;
      for (int c = 0; c <= FRAME + 2; c++) begin
        e = (c < 2 || c >= FRAME + 2) ? 1'b1 : fr[(c - 2) / DIV];
        if (hist[t0 + c] !== e) mism++;
      end
      check($sformatf("frame_%0d_wrong_cycles", i), mism, 32'd0);
    end

    // a write to the STATUS offset is ignored
    model_clear();
    t0 = cur();
    wr(UART_STATUS_OFF, 32'hAB);
    run_to(t0 + 30);
    rd(UART_STATUS_OFF, d);
    check("status_write_ignored", d, 32'h3);
    check_wave("status_write", t0, cur());

    // back-to-back bytes: no idle gap between frames
    model_clear();
    t0 = cur();
    wr(UART_DATA_OFF, 32'hA5); model_add(8'hA5, t0);
    wr(UART_DATA_OFF, 32'h01); model_add(8'h01, t0 + 1);
    run_to(t0 + 2 + FRAME);
    check("b2b_prev_stop", {31'd0, hist[t0 + 1 + FRAME]}, 32'd1);
    check("b2b_next_start", {31'd0, hist[t0 + 2 + FRAME]}, 32'd0);
    wait_idle("b2b");
    check_wave("b2b", t0, cur());

    // overflow: six writes into an idle controller with a four-entry FIFO
    model_clear();
    t0 = cur();
    for (int i = 0; i < 6; i++) begin
      wr(UART_DATA_OFF, 32'h11 * (i + 1));
      if (i < 5) model_add(8'(8'h11 * (i + 1)), t0 + i);
    end
    rd(UART_STATUS_OFF, d);
    check("ovf_status", d, 32'h4);
    rd(UART_STATUS_OFF, d);
    check("ovf_cleared", d, 32'h0);
    wait_idle("ovf");
    check_wave("ovf", t0, cur());

    // dropped write in the same cycle as a clearing STATUS read: set wins
    model_clear();
    t0 = cur();
    for (int i = 0; i < 5; i++) begin
      wr(UART_DATA_OFF, 32'h21 + i);
      model_add(8'(8'h21 + i), t0 + i);
    end
    bus_op(1'b1, UART_DATA_OFF, 32'h99, 1'b1, UART_STATUS_OFF, d);
    check("race_read", d, 32'h0);
    rd(UART_STATUS_OFF, d);
    check("race_ovf_kept", d, 32'h4);
    rd(UART_DATA_OFF, d);
    check("data_read_zero", d, 32'h0);
    rd(UART_STATUS_OFF, d);
    check("data_read_no_pop", d, 32'h0);
    wait_idle("race");
    check_wave("race", t0, cur());

    // reset in the middle of a frame with a second byte queued
    model_clear();
    t0 = cur();
    wr(UART_DATA_OFF, 32'h55); model_add(8'h55, t0);
    wr(UART_DATA_OFF, 32'h3C);
    run_to(t0 + 20);
    rd(UART_STATUS_OFF, d);
    check("pre_rst_status", d, 32'h1);
    run_to(t0 + 40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_rdata", bus_i.rdata, 32'd0);
    check_wave("pre_rst", t0, t0 + 40);
    run_to(t0 + 41 + 2 * FRAME);
    model_clear();
    check_wave("post_rst_quiet", t0 + 41, cur());
    rd(UART_STATUS_OFF, d);
    check("post_rst_status", d, 32'h3);

    // randomized bursts with random gaps and interleaved DATA reads
    for (int n = 0; n < 12; n++) begin
      model_clear();
      t0 = cur();
      for (int j = 0; j < $urandom_range(1, DEPTH); j++) begin
        for (int g = 0; g < $urandom_range(0, 3); g++) begin
          if ($urandom_range(0, 1) == 1) begin
            a = $urandom();
            a[2] = 1'b1;
            rd(a, d);
            check($sformatf("rand_data_read_%0d", n), d, 32'h0);
          end else begin
            tick();
          end
        end
        a = $urandom();
        a[2] = 1'b1;
        b = 8'($urandom_range(0, 255));
        model_add(b, cur());
        wr(a, {$urandom_range(0, 32'hFF_FFFF), b});
      end
      if ($urandom_range(0, 1) == 1) run_to(cur() + $urandom_range(0, FRAME));
      wait_idle($sformatf("rand_%0d", n));
      check_wave($sformatf("rand_%0d", n), t0, cur());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
